// File: rtl/basic_cpu.sv
// 4-bit microcoded accumulator CPU: three-step sequencer (add F1, unary op F2, logic merge F3).
// Optional macro BASIC_CPU_SAT_EN makes the S0 add saturate at 4'hF instead of wrapping.
module basic_cpu #(
  parameter logic [3:0] RESET_VAL = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] n,
  output logic [3:0] out
);

  typedef enum logic [1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    SBAD = 2'd3
  } step_t;

  step_t      step_r;
  step_t      step_nxt_s;
  logic [3:0] acc_r;
  logic [3:0] acc_nxt_s;
  logic [3:0] f1_s;
  logic [2:0] f2_s;
  logic [1:0] f3_s;

  assign f1_s = n[8:5];
  assign f2_s = n[4:2];
  assign f3_s = n[1:0];

  function automatic logic [3:0] add_f1(input logic [3:0] acc, input logic [3:0] f1);
    logic [3:0] res;
`ifdef BASIC_CPU_SAT_EN
    logic [4:0] sum;
    sum = {1'b0, acc} + {1'b0, f1};
    if (sum[4]) begin
      res = 4'hF;
    end else begin
      res = sum[3:0];
    end
`else
    res = acc + f1;
`endif
    return res;
  endfunction

  function automatic logic [3:0] unary_op(input logic [3:0] acc, input logic [2:0] op);
    logic [3:0] res;
    case (op)
      3'b000:  res = acc;
      3'b001:  res = acc + 4'd1;
      3'b010:  res = acc - 4'd1;
      3'b011:  res = ~acc;
      3'b100:  res = {acc[2:0], 1'b0};
      3'b101:  res = {1'b0, acc[3:1]};
      3'b110:  res = {acc[2:0], acc[3]};
      3'b111:  res = 4'h0;
      default: res = acc;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] merge_op(input logic [3:0] acc, input logic [3:0] f1,
                                          input logic [1:0] op);
    logic [3:0] res;
    case (op)
      2'b00:   res = acc;
      2'b01:   res = acc ^ f1;
      2'b10:   res = acc & f1;
      2'b11:   res = acc | f1;
      default: res = acc;
    endcase
    return res;
  endfunction

  // Execute the current step and pick the next one; the upset code 3 recovers to S0.
  always_comb begin
    acc_nxt_s  = acc_r;
    step_nxt_s = S0;
    case (step_r)
      S0: begin
        acc_nxt_s  = add_f1(acc_r, f1_s);
        step_nxt_s = S1;
      end
      S1: begin
        acc_nxt_s  = unary_op(acc_r, f2_s);
        step_nxt_s = S2;
      end
      S2: begin
        acc_nxt_s  = merge_op(acc_r, f1_s, f3_s);
        step_nxt_s = S0;
      end
      default: begin
        acc_nxt_s  = acc_r;
        step_nxt_s = S0;
      end
    endcase
  end

  // Step and accumulator registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_r <= S0;
      acc_r  <= RESET_VAL;
    end else begin
      step_r <= step_nxt_s;
      acc_r  <= acc_nxt_s;
    end
  end

  assign out = acc_r;

endmodule

// File: tb/tb_basic_cpu.sv
// Directed self-checking bench for basic_cpu; expectations follow BASIC_CPU_SAT_EN when defined.
module tb_basic_cpu;

  logic       clk;
  logic       reset;
  logic [8:0] n;
  logic [3:0] out;

  int n_cmp;
  int n_err;

  basic_cpu dut (
    .clk   (clk),
    .reset (reset),
    .n     (n),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse reset low across one clock edge, release it mid-cycle so the next edge executes S0.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] exp [6];
    n     = 9'b0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out !== 4'h0) begin
        n_err++;
        $display("FAIL reset_hold cycle %0d: got %h expected 0", i, out);
      end
    end
    exp = '{4'h5, 4'h2, 4'h0, 4'h5, 4'h2, 4'h0};
    @(negedge clk);
    n     = 9'b0101_101_10;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out !== exp[i]) begin
        n_err++;
        $display("FAIL shr_and edge %0d: got %h expected %h", i + 1, out, exp[i]);
      end
    end
  endtask

  task automatic test_wrap_sat();
    logic [3:0] exp [6];
`ifdef BASIC_CPU_SAT_EN
    exp = '{4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF};
`else
    exp = '{4'hF, 4'h0, 4'hF, 4'hE, 4'h1, 4'hF};
`endif
    n = 9'b1111_011_11;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out !== exp[i]) begin
        n_err++;
        $display("FAIL wrap_sat edge %0d: got %h expected %h", i + 1, out, exp[i]);
      end
    end
  endtask

  task automatic test_rotate_xor();
    logic [3:0] exp [6];
    exp = '{4'h3, 4'h6, 4'h5, 4'h8, 4'h1, 4'h2};
    n = 9'b0011_110_01;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out !== exp[i]) begin
        n_err++;
        $display("FAIL rol_xor edge %0d: got %h expected %h", i + 1, out, exp[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    n = 9'b0101_001_00;
    do_reset();
    @(posedge clk);
    #1;
    n_cmp++;
    if (out !== 4'h5) begin
      n_err++;
      $display("FAIL async_pre: got %h expected 5", out);
    end
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (out !== 4'h0) begin
      n_err++;
      $display("FAIL async_clear: got %h expected 0", out);
    end
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out !== 4'h5) begin
      n_err++;
      $display("FAIL async_s0: got %h expected 5", out);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out !== 4'h6) begin
      n_err++;
      $display("FAIL async_s1_inc: got %h expected 6", out);
    end
  endtask

  task automatic test_f2_sweep();
    logic [3:0] exp [8];
    logic [2:0] op;
    exp = '{4'h6, 4'h7, 4'h5, 4'h9, 4'hC, 4'h3, 4'hC, 4'h0};
    for (int i = 0; i < 8; i++) begin
      op = i[2:0];
      n  = {4'h6, op, 2'b00};
      do_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      n_cmp++;
      if (out !== exp[i]) begin
        n_err++;
        $display("FAIL f2_op %0d: got %h expected %h", i, out, exp[i]);
      end
    end
  endtask

  task automatic test_live_change();
    n = 9'b0101_111_11;
    do_reset();
    @(posedge clk);
    #1;
    n_cmp++;
    if (out !== 4'h5) begin
      n_err++;
      $display("FAIL live_s0: got %h expected 5", out);
    end
    n = 9'b0001_111_11;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out !== 4'h0) begin
      n_err++;
      $display("FAIL live_s1_clr: got %h expected 0", out);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out !== 4'h1) begin
      n_err++;
      $display("FAIL live_s2_or: got %h expected 1", out);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    n     = 9'b0;
    test_reset();
    test_wrap_sat();
    test_rotate_xor();
    test_async_reset();
    test_f2_sweep();
    test_live_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
